// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: arbitrates pending requests at an opcode-fetch boundary,
// then pushes PCH/PCL/P and reads the vector. NMI support is built in with INT_SEQ_NMI_EN.
module int_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RDY,
    input  logic        sync,
    input  logic        I_flag,
    input  logic        TIQ,
    input  logic        IRQ1,
    input  logic        IRQ2,
    input  logic        NMI_n,
    output logic        take,
    output logic        busy,
    output logic        stk_we,
    output logic [1:0]  stk_sel,
    output logic        vec_re,
    output logic [15:0] vec_addr,
    output logic        set_I,
    output logic        done,
    output logic [1:0]  src
);

    localparam int unsigned ST_W   = 3;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned ADDR_W = 16;

    localparam logic [ST_W-1:0] S_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] S_PUSH_PCH = 3'd1;
    localparam logic [ST_W-1:0] S_PUSH_PCL = 3'd2;
    localparam logic [ST_W-1:0] S_PUSH_P   = 3'd3;
    localparam logic [ST_W-1:0] S_VEC_LO   = 3'd4;
    localparam logic [ST_W-1:0] S_VEC_HI   = 3'd5;

    localparam logic [SRC_W-1:0] SRC_IRQ2 = 2'd0;
    localparam logic [SRC_W-1:0] SRC_IRQ1 = 2'd1;
    localparam logic [SRC_W-1:0] SRC_TIQ  = 2'd2;

    localparam logic [1:0] SEL_PCH = 2'd0;
    localparam logic [1:0] SEL_PCL = 2'd1;
    localparam logic [1:0] SEL_P   = 2'd2;

    localparam logic [ADDR_W-1:0] VEC_BASE = 16'hFFF6;

    logic [ST_W-1:0]   state_q, state_d;
    logic [SRC_W-1:0]  src_q, src_d, src_sel;
    logic              busy_q, busy_d;
    logic              stk_we_q, stk_we_d;
    logic [1:0]        stk_sel_q, stk_sel_d;
    logic              vec_re_q, vec_re_d;
    logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
    logic              want;

`ifdef INT_SEQ_NMI_EN
    localparam logic [SRC_W-1:0] SRC_NMI = 2'd3;

    logic nmi_n_q;
    logic nmi_pend_q, nmi_pend_d;
    logic nmi_edge;

    // Edge detector runs every cycle, independent of RDY
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_n_q    <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_n_q    <= NMI_n;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign nmi_edge = nmi_n_q & ~NMI_n;

    // A fresh edge in the same cycle as the NMI take keeps the request pending
    always_comb begin
        nmi_pend_d = nmi_pend_q;
        if (take && (src_sel == SRC_NMI)) begin
            nmi_pend_d = 1'b0;
        end
        if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
    end

    assign want = nmi_pend_q | (~I_flag & (TIQ | IRQ1 | IRQ2));
`else
    logic unused_nmi_n;

    assign unused_nmi_n = NMI_n;
    assign want         = ~I_flag & (TIQ | IRQ1 | IRQ2);
`endif

    // Fixed priority: NMI > TIQ > IRQ1 > IRQ2
    always_comb begin
        src_sel = SRC_IRQ2;
        if (TIQ) begin
            src_sel = SRC_TIQ;
        end else if (IRQ1) begin
            src_sel = SRC_IRQ1;
        end
`ifdef INT_SEQ_NMI_EN
        if (nmi_pend_q) begin
            src_sel = SRC_NMI;
        end
`endif
    end

    assign take  = reset_n & (state_q == S_IDLE) & sync & RDY & want;
    assign set_I = (state_q == S_VEC_LO) & RDY;
    assign done  = (state_q == S_VEC_HI) & RDY;

    // Next state, latched source, and registered decode of the next state
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        busy_d     = 1'b0;
        stk_we_d   = 1'b0;
        stk_sel_d  = SEL_PCH;
        vec_re_d   = 1'b0;
        vec_addr_d = '0;

        if (RDY) begin
            case (state_q)
                S_IDLE: begin
                    if (take) begin
                        state_d = S_PUSH_PCH;
                        src_d   = src_sel;
                    end
                end
                S_PUSH_PCH: state_d = S_PUSH_PCL;
                S_PUSH_PCL: state_d = S_PUSH_P;
                S_PUSH_P:   state_d = S_VEC_LO;
                S_VEC_LO:   state_d = S_VEC_HI;
                S_VEC_HI:   state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);

        case (state_d)
            S_PUSH_PCH: begin
                stk_we_d  = 1'b1;
                stk_sel_d = SEL_PCH;
            end
            S_PUSH_PCL: begin
                stk_we_d  = 1'b1;
                stk_sel_d = SEL_PCL;
            end
            S_PUSH_P: begin
                stk_we_d  = 1'b1;
                stk_sel_d = SEL_P;
            end
            S_VEC_LO: begin
                vec_re_d   = 1'b1;
                vec_addr_d = VEC_BASE + ADDR_W'({src_d, 1'b0});
            end
            S_VEC_HI: begin
                vec_re_d   = 1'b1;
                vec_addr_d = VEC_BASE + ADDR_W'({src_d, 1'b0}) + ADDR_W'(1);
            end
            default: begin
                vec_re_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_IRQ2;
            busy_q     <= 1'b0;
            stk_we_q   <= 1'b0;
            stk_sel_q  <= SEL_PCH;
            vec_re_q   <= 1'b0;
            vec_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            stk_we_q   <= stk_we_d;
            stk_sel_q  <= stk_sel_d;
            vec_re_q   <= vec_re_d;
            vec_addr_q <= vec_addr_d;
        end
    end

    assign busy     = busy_q;
    assign stk_we   = stk_we_q;
    assign stk_sel  = stk_sel_q;
    assign vec_re   = vec_re_q;
    assign vec_addr = vec_addr_q;
    assign src      = src_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed vector table, hand sequences, and randomized
// stimulus checked against a sequence-position reference model.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, RDY, sync, I_flag, TIQ, IRQ1, IRQ2, NMI_n;
    logic        take, busy, stk_we, vec_re, set_I, done;
    logic [1:0]  stk_sel, src;
    logic [15:0] vec_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .RDY      (RDY),
        .sync     (sync),
        .I_flag   (I_flag),
        .TIQ      (TIQ),
        .IRQ1     (IRQ1),
        .IRQ2     (IRQ2),
        .NMI_n    (NMI_n),
        .take     (take),
        .busy     (busy),
        .stk_we   (stk_we),
        .stk_sel  (stk_sel),
        .vec_re   (vec_re),
        .vec_addr (vec_addr),
        .set_I    (set_I),
        .done     (done),
        .src      (src)
    );

    // in = {rdy, sync, i_flag, tiq, irq1, irq2, nmi_n}
    typedef struct {
        logic [6:0]  in;
        logic [25:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: position in sequence (0 idle, 1..5 the five steps)
    int m_k;
    int m_src;
    bit m_pend;
    bit m_prev;

    function automatic logic [25:0] pk(bit tk, bit bsy, bit we, logic [1:0] sel, bit re,
                                       logic [15:0] addr, bit si, bit dn, logic [1:0] s);
        return {tk, bsy, we, sel, re, addr, si, dn, s};
    endfunction

    function automatic logic [25:0] dut_out();
        return {take, busy, stk_we, stk_sel, vec_re, vec_addr, set_I, done, src};
    endfunction

    function automatic vec_t mk(logic [6:0] in, logic [25:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_want();
        return m_pend || (!I_flag && (TIQ || IRQ1 || IRQ2));
    endfunction

    function automatic int m_sel();
        if (m_pend) return 3;
        if (TIQ)    return 2;
        if (IRQ1)   return 1;
        return 0;
    endfunction

    function automatic logic [25:0] model_out();
        bit          tk;
        logic [15:0] base;
        logic [15:0] addr;
        tk   = (m_k == 0) && sync && RDY && m_want();
        base = 16'hFFF6 + 16'(2 * m_src);
        addr = (m_k == 4) ? base : (m_k == 5) ? base + 16'd1 : 16'h0000;
        return pk(tk, m_k != 0, (m_k >= 1 && m_k <= 3),
                  (m_k >= 1 && m_k <= 3) ? 2'(m_k - 1) : 2'd0,
                  m_k >= 4, addr, (m_k == 4) && RDY, (m_k == 5) && RDY, 2'(m_src));
    endfunction

    task automatic m_advance();
        bit tk;
        int sel;
        tk  = (m_k == 0) && sync && RDY && m_want();
        sel = m_sel();
        if (RDY) begin
            if (m_k == 0) begin
                if (tk) begin
                    m_k   = 1;
                    m_src = sel;
                end
            end else begin
                m_k = (m_k == 5) ? 0 : m_k + 1;
            end
        end
`ifdef INT_SEQ_NMI_EN
        if (tk && sel == 3) m_pend = 1'b0;
        if (m_prev && !NMI_n) m_pend = 1'b1;
        m_prev = NMI_n;
`endif
    endtask

    task automatic drive(input logic [6:0] in);
        RDY    = in[6];
        sync   = in[5];
        I_flag = in[4];
        TIQ    = in[3];
        IRQ1   = in[2];
        IRQ2   = in[1];
        NMI_n  = in[0];
    endtask

    // One clock: drive after the falling edge, check, then advance the model
    task automatic run(input string name, input logic [6:0] in, input bit use_exp,
                       input logic [25:0] exp);
        @(negedge clk);
        drive(in);
        #1;
        chk(name, 32'(dut_out()), 32'(use_exp ? exp : model_out()));
        m_advance();
    endtask

    task automatic m_reset();
        m_k    = 0;
        m_src  = 0;
        m_pend = 1'b0;
        m_prev = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(7'b1_1_0_0_1_0_0);
        m_reset();
        #1;
        chk("reset outputs", 32'(dut_out()), 32'h0);
        @(negedge clk);
        #1;
        chk("reset held", 32'(dut_out()), 32'h0);
        drive(7'b1_0_1_0_0_0_1);
        reset_n = 1'b1;
    endtask

    initial begin
        logic nmi_lvl;
        reset_n = 1'b0;
        drive(7'b1_0_1_0_0_0_1);
        m_reset();

        // IRQ1 sequence, request dropped after take
        tbl.push_back(mk(7'b1_1_0_0_1_0_1, pk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b1_1_0_0_0_0_1, pk(0, 1, 1, 0, 0, 16'h0000, 0, 0, 1)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 1)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 1, 2, 0, 16'h0000, 0, 0, 1)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 0, 0, 1, 16'hFFF8, 1, 0, 1)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 0, 0, 1, 16'hFFF9, 0, 1, 1)));
        tbl.push_back(mk(7'b1_0_1_1_1_1_1, pk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 1)));
        // All levels masked by I_flag, then unmasked: TIQ wins
        tbl.push_back(mk(7'b1_1_1_1_1_1_1, pk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 1)));
        tbl.push_back(mk(7'b1_1_0_1_1_1_1, pk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1)));
        tbl.push_back(mk(7'b1_1_0_1_1_1_1, pk(0, 1, 1, 0, 0, 16'h0000, 0, 0, 2)));
        tbl.push_back(mk(7'b1_1_0_1_1_1_1, pk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 2)));
        tbl.push_back(mk(7'b1_1_0_1_1_1_1, pk(0, 1, 1, 2, 0, 16'h0000, 0, 0, 2)));
        tbl.push_back(mk(7'b1_1_0_1_1_1_1, pk(0, 1, 0, 0, 1, 16'hFFFA, 1, 0, 2)));
        tbl.push_back(mk(7'b1_1_0_1_1_1_1, pk(0, 1, 0, 0, 1, 16'hFFFB, 0, 1, 2)));
        tbl.push_back(mk(7'b1_0_0_1_1_1_1, pk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 2)));
        // IRQ2 with three RDY=0 cycles in PUSH_PCL and one in VEC_LO
        tbl.push_back(mk(7'b1_1_0_0_0_1_1, pk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 2)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 1, 0, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b0_0_0_0_0_0_1, pk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b0_1_0_0_0_0_1, pk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b0_0_0_0_0_0_1, pk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 1, 1, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 1, 2, 0, 16'h0000, 0, 0, 0)));
        tbl.push_back(mk(7'b0_0_0_0_0_0_1, pk(0, 1, 0, 0, 1, 16'hFFF6, 0, 0, 0)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 0, 0, 1, 16'hFFF6, 1, 0, 0)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 1, 0, 0, 1, 16'hFFF7, 0, 1, 0)));
        tbl.push_back(mk(7'b1_0_0_0_0_0_1, pk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0)));

        do_reset();
        foreach (tbl[i]) begin
            run($sformatf("table[%0d]", i), tbl[i].in, 1'b1, tbl[i].exp);
        end

`ifdef INT_SEQ_NMI_EN
        // NMI edge while masked, then taken; held low gives no second take
        run("nmi idle", 7'b1_0_1_0_0_0_1, 1'b0, '0);
        run("nmi fall", 7'b1_0_1_0_0_0_0, 1'b0, '0);
        run("nmi take", 7'b1_1_1_0_0_0_0, 1'b0, '0);
        chk("nmi take strobe", 32'(take), 32'h1);
        for (int i = 0; i < 5; i++) begin
            run("nmi seq", 7'b1_1_1_0_0_0_0, 1'b0, '0);
            if (i == 0) chk("nmi src", 32'(src), 32'h3);
            if (i == 3) chk("nmi vec lo", 32'(vec_addr), 32'hFFFC);
            if (i == 4) chk("nmi vec hi", 32'(vec_addr), 32'hFFFD);
        end
        for (int i = 0; i < 4; i++) begin
            run("nmi held low", 7'b1_1_1_0_0_0_0, 1'b0, '0);
            chk("nmi no retake", 32'(take), 32'h0);
        end
        // New edge on the very cycle the pending NMI is taken
        run("nmi rise", 7'b1_0_1_0_0_0_1, 1'b0, '0);
        run("nmi fall2", 7'b1_0_1_0_0_0_0, 1'b0, '0);
        run("nmi rise2", 7'b1_0_1_0_0_0_1, 1'b0, '0);
        run("nmi take+edge", 7'b1_1_1_0_0_0_0, 1'b0, '0);
        chk("nmi take+edge strobe", 32'(take), 32'h1);
        for (int i = 0; i < 5; i++) run("nmi seq2", 7'b1_0_1_0_0_0_0, 1'b0, '0);
        run("nmi repend", 7'b1_1_1_0_0_0_0, 1'b0, '0);
        chk("nmi still pending", 32'(take), 32'h1);
        for (int i = 0; i < 5; i++) run("nmi seq3", 7'b1_0_1_0_0_0_1, 1'b0, '0);
`else
        // Without NMI support an edge must not cause a take
        run("nonmi idle", 7'b1_0_1_0_0_0_1, 1'b0, '0);
        run("nonmi fall", 7'b1_0_1_0_0_0_0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            run("nonmi sync", 7'b1_1_1_0_0_0_0, 1'b0, '0);
            chk("nonmi take", 32'(take), 32'h0);
        end
        run("nonmi rise", 7'b1_1_1_0_0_0_1, 1'b0, '0);
`endif

        // Reset asserted during VEC_LO aborts the sequence immediately
        run("abort take", 7'b1_1_0_0_1_0_1, 1'b0, '0);
        for (int i = 0; i < 4; i++) run("abort seq", 7'b1_0_0_0_0_0_1, 1'b0, '0);
        chk("abort in vec_lo", 32'(vec_re), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort vec_re", 32'(vec_re), 32'h0);
        chk("abort done", 32'(done), 32'h0);
        chk("abort vec_addr", 32'(vec_addr), 32'h0);
        do_reset();
        run("post abort", 7'b1_0_0_0_0_0_1, 1'b0, '0);

        // Randomized stimulus against the model
        nmi_lvl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] in;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                nmi_lvl = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) nmi_lvl = ~nmi_lvl;
            in = {1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0), nmi_lvl};
            run($sformatf("random[%0d]", i), in, 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
